// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the iterative multiply/divide unit.
//   mdu_op_e      operation codes presented on the op field
//   mdu_state_e   sequencer states (IDLE, RUN)
//   mdu_ctl_t     decoded datapath controls latched at accept
// Build option: define MDU_SIGNED_EN to make ops 4/5/6 signed (adds op_is_signed).
package mdu_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int AW_DEFAULT   = 5;
    localparam int MDU_LAT      = XLEN_DEFAULT;

    typedef enum logic [2:0] {
        OP_MUL   = 3'd0,
        OP_MULHU = 3'd1,
        OP_DIVU  = 3'd2,
        OP_REMU  = 3'd3,
        OP_MULH  = 3'd4,
        OP_DIV   = 3'd5,
        OP_REM   = 3'd6,
        OP_RSVD  = 3'd7
    } mdu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_e;

    // sel_hi picks the high product word for multiplies, the remainder for divides
    typedef struct packed {
        logic is_div;
        logic sel_hi;
    } mdu_ctl_t;

    function automatic mdu_ctl_t decode_op(mdu_op_e op);
        mdu_ctl_t ctl;
        ctl = '0;
        case (op)
            OP_MULHU, OP_MULH: ctl.sel_hi = 1'b1;
            OP_DIVU,  OP_DIV:  ctl.is_div = 1'b1;
            OP_REMU,  OP_REM:  begin
                ctl.is_div = 1'b1;
                ctl.sel_hi = 1'b1;
            end
            default: ctl = '0;
        endcase
        return ctl;
    endfunction

`ifdef MDU_SIGNED_EN
    function automatic logic op_is_signed(mdu_op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction
`endif

endpackage

// File: rtl/mdu_seq_if.sv
// mdu_seq_if: request handshake and register-bank write-back bundle of mdu_seq.
//   in_valid/in_ready/op/rs1_data/rs2_data/rd_addr  request side
//   busy                                            operation in progress
//   we3/wa3/wd3                                     write port of the register bank
// master = requester/bank side, slave = mdu_seq.
interface mdu_seq_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) ();
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [AW-1:0]   rd_addr;
    logic            busy;
    logic            we3;
    logic [AW-1:0]   wa3;
    logic [XLEN-1:0] wd3;

    modport master (
        output in_valid, op, rs1_data, rs2_data, rd_addr,
        input  in_ready, busy, we3, wa3, wd3
    );

    modport slave (
        input  in_valid, op, rs1_data, rs2_data, rd_addr,
        output in_ready, busy, we3, wa3, wd3
    );
endinterface

// File: rtl/mdu_div_core.sv
// mdu_div_core: restoring divider, one quotient bit per step.
//   clk, rst        clock, asynchronous active-low reset
//   load_i          load dividend/divisor magnitudes, clear remainder
//   step_i          perform one restoring-subtract step
//   dividend_i      dividend magnitude
//   divisor_i       divisor magnitude
//   sign_a_i/b_i    operand signs (only with MDU_SIGNED_EN)
//   quo_o, rem_o    results as they will stand after the current step,
//                   sign-corrected; valid on the final step
module mdu_div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            step_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
`ifdef MDU_SIGNED_EN
    input  logic            sign_a_i,
    input  logic            sign_b_i,
`endif
    output logic [XLEN-1:0] quo_o,
    output logic [XLEN-1:0] rem_o
);

    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN:0]   shifted, diff;
    logic            ge;
    logic [XLEN-1:0] rem_step, quo_step;

    // Dividend bits shift out of quo_q into the partial remainder while
    // quotient bits shift in from the bottom.
    assign shifted  = {rem_q, quo_q[XLEN-1]};
    assign diff     = shifted - {1'b0, dvs_q};
    assign ge       = ~diff[XLEN];
    assign rem_step = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign quo_step = {quo_q[XLEN-2:0], ge};

    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        if (load_i) begin
            rem_d = '0;
            quo_d = dividend_i;
            dvs_d = divisor_i;
        end else if (step_i) begin
            rem_d = rem_step;
            quo_d = quo_step;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

`ifdef MDU_SIGNED_EN
    logic neg_quo_q, neg_quo_d;
    logic neg_rem_q, neg_rem_d;

    assign neg_quo_d = load_i ? (sign_a_i ^ sign_b_i) : neg_quo_q;
    assign neg_rem_d = load_i ? sign_a_i : neg_rem_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    // Divide by zero keeps the all-ones quotient whatever the signs.
    assign quo_o = (neg_quo_q && (dvs_q != '0)) ? -quo_step : quo_step;
    assign rem_o = neg_rem_q ? -rem_step : rem_step;
`else
    assign quo_o = quo_step;
    assign rem_o = rem_step;
`endif

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: iterative multiply/divide unit feeding the register bank write port.
//   clk       clock
//   rst       asynchronous active-low reset
//   bus       mdu_seq_if.slave: in_valid/in_ready request handshake with
//             op/rs1_data/rs2_data/rd_addr, busy, and we3/wa3/wd3 write-back
// Fixed latency of XLEN edges from accept to the we3 cycle for every op.
// Build option: MDU_SIGNED_EN makes ops 4/5/6 signed; otherwise they run as 1/2/3.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int AW   = AW_DEFAULT
) (
    input  logic     clk,
    input  logic     rst,
    mdu_seq_if.slave bus
);

    localparam int            CW       = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    mdu_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    mdu_ctl_t          ctl_q, ctl_d;
    logic [AW-1:0]     rd_q, rd_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic              we3_q, we3_d;
    logic [AW-1:0]     wa3_q, wa3_d;
    logic [XLEN-1:0]   wd3_q, wd3_d;

    mdu_op_e           op_in;
    logic              accept;
    logic [XLEN-1:0]   opa_mag, opb_mag;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod_step, prod_res;
    logic [XLEN-1:0]   div_quo, div_rem, result;

    assign op_in  = mdu_op_e'(bus.op);
    assign accept = (state_q == IDLE) && bus.in_valid;

`ifdef MDU_SIGNED_EN
    logic sign_a, sign_b;
    logic neg_p_q, neg_p_d;

    assign sign_a   = op_is_signed(op_in) && bus.rs1_data[XLEN-1];
    assign sign_b   = op_is_signed(op_in) && bus.rs2_data[XLEN-1];
    assign opa_mag  = sign_a ? -bus.rs1_data : bus.rs1_data;
    assign opb_mag  = sign_b ? -bus.rs2_data : bus.rs2_data;
    assign neg_p_d  = accept ? (sign_a ^ sign_b) : neg_p_q;
    assign prod_res = neg_p_q ? -prod_step : prod_step;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) neg_p_q <= 1'b0;
        else      neg_p_q <= neg_p_d;
    end
`else
    assign opa_mag  = bus.rs1_data;
    assign opb_mag  = bus.rs2_data;
    assign prod_res = prod_step;
`endif

    // Shift-add: multiplier sits in the low half of prod_q and is consumed
    // LSB first while partial sums enter the high half.
    assign mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign prod_step = {mul_sum, prod_q[XLEN-1:1]};

    mdu_div_core #(.XLEN(XLEN)) u_div (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept),
        .step_i     (state_q == RUN),
        .dividend_i (opa_mag),
        .divisor_i  (opb_mag),
`ifdef MDU_SIGNED_EN
        .sign_a_i   (sign_a),
        .sign_b_i   (sign_b),
`endif
        .quo_o      (div_quo),
        .rem_o      (div_rem)
    );

    always_comb begin
        result = prod_res[XLEN-1:0];
        if (ctl_q.is_div)      result = ctl_q.sel_hi ? div_rem : div_quo;
        else if (ctl_q.sel_hi) result = prod_res[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctl_d   = ctl_q;
        rd_d    = rd_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        we3_d   = 1'b0;
        wa3_d   = wa3_q;
        wd3_d   = wd3_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    ctl_d   = decode_op(op_in);
                    rd_d    = bus.rd_addr;
                    mcand_d = opa_mag;
                    prod_d  = {{XLEN{1'b0}}, opb_mag};
                end
            end
            RUN: begin
                prod_d = prod_step;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    we3_d   = 1'b1;
                    wa3_d   = rd_q;
                    wd3_d   = result;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ctl_q   <= '0;
            rd_q    <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
            we3_q   <= 1'b0;
            wa3_q   <= '0;
            wd3_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctl_q   <= ctl_d;
            rd_q    <= rd_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            we3_q   <= we3_d;
            wa3_q   <= wa3_d;
            wd3_q   <= wd3_d;
        end
    end

    assign bus.in_ready = (state_q == IDLE);
    assign bus.busy     = (state_q == RUN);
    assign bus.we3      = we3_q;
    assign bus.wa3      = wa3_q;
    assign bus.wd3      = wd3_q;

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Iterative multiply/divide unit that sits directly upstream of the 32-entry register bank.
- Consumes the bank's read-port data (rd1/rd2 → rs1_data/rs2_data) with a destination address.
- After a fixed XLEN-cycle iteration, produces a one-cycle write-back pulse on we3/wa3/wd3, which connect straight into the bank's write port.
- Single-issue, valid/ready input handshake; the write port has no backpressure.

Parameters:
- XLEN, 32, operand/result width; also the iteration count.
- AW, 5, register address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operation request.
- in_ready  out  1  high iff state==IDLE.
- op  in  3  operation code (see Behaviour).
- rs1_data  in  XLEN  operand A (multiplicand/dividend).
- rs2_data  in  XLEN  operand B (multiplier/divisor).
- rd_addr  in  AW  destination register.
- busy  out  1  high iff state==RUN.
- we3  out  1  write-back enable, one-cycle pulse.
- wa3  out  AW  write-back address.
- wd3  out  XLEN  write-back data.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0, we3=0, wa3=0, wd3=0, busy=0; in_ready=1 follows from IDLE.
- Any in-flight operation is discarded on reset; no write-back ever occurs for it.
- Op encoding:
  - 0 MUL: low XLEN bits of A*B.
  - 1 MULHU: high XLEN bits, unsigned.
  - 2 DIVU: unsigned quotient.
  - 3 REMU: unsigned remainder.
  - 4 MULH, 5 DIV, 6 REM: signed ops (see Optional Feature).
  - 7 reserved, executed as MUL.
- States: IDLE, RUN. No other states.
- IDLE → RUN on the edge where in_valid && in_ready; that edge is E0.
- At E0, latch op, operands and rd_addr; clear counter.
- RUN: one shift-add (multiply) or restoring-subtract (divide) step per edge, E1..E32; counter increments each step.
- On E32 (counter==XLEN-1): register wd3=result, wa3=latched rd_addr, we3=1; state → IDLE.
- On the next edge, we3 returns to 0 unless a new result completes. wa3/wd3 hold their last values.
- Latency: we3 is high during the cycle following E32, exactly XLEN edges after accept. Fixed for all ops and operands; no early-out.
- in_valid is ignored while in RUN; operand inputs are don't-care after E0.
- A new operation may be accepted on the edge immediately after E32, while we3 is high (back-to-back, no bubble beyond the IDLE cycle).
- Unsigned divide by zero: quotient = all ones; remainder = dividend. Full latency still applies.
- rd_addr=0 is written back like any other address; the register bank owns any x0 semantics.
- Multiply uses a 2*XLEN accumulator; no overflow detection.

Optional Feature:
- Macro: MDU_SIGNED_EN.
- Defined: ops 4/5/6 are signed.
  - Operation runs on magnitudes; result sign is corrected in the final step.
  - Quotient sign = sA^sB; remainder sign = sA.
  - Signed divide by zero: quotient = all ones, remainder = dividend.
  - Overflow 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
  - Latency is unchanged.
- Not defined: ops 4/5/6 execute as 1/2/3 respectively. No sign logic is synthesised.

Decomposition:
- Package mdu_pkg:
  - mdu_op_e enum for the op codes.
  - mdu_state_e enum {IDLE, RUN}.
  - XLEN_DEFAULT and AW_DEFAULT constants.
  - MDU_LAT = XLEN latency constant, for benches.
- One natural sub-module: mdu_div_core.
  - Restoring divider step datapath: remainder/quotient registers plus the sign fix-up.
- Multiply stays inline in mdu_seq.

Test Plan:
1. Reset: hold rst=0 for 2 cycles → we3=0, wa3=0, wd3=0, busy=0, in_ready=1. Release, idle 5 cycles → we3 stays 0.
2. MUL rs1=0x00001234, rs2=0x00000011, rd=3 → busy for 32 cycles, then we3=1 for exactly one cycle with wa3=3, wd3=0x00013574. Likewise MUL 0xFFFFFFFF*0xFFFFFFFF → 0x00000001; MULHU on the same operands → 0xFFFFFFFE.
3. DIVU 100/7 rd=5 → wd3=0x0000000E; REMU 100/7 → 0x00000002. DIVU 0x55/0 → 0xFFFFFFFF; REMU 0x55/0 → 0x00000055. All at 32-cycle latency.
4. Back-to-back: in_valid held high with ops MUL(2,3,rd=1) then DIVU(9,2,rd=2) → second accepted on the edge after the first completes. Writes: reg1=6, then reg2=4. Inputs changed during RUN do not affect results. Write-back into the register bank is then read back via ra1/ra2 and matches.
5. Reset mid-op: assert rst low at iteration 10 of DIVU → no we3 pulse; in_ready=1 after release. A fresh MUL 3*4 rd=7 then yields wd3=0x0000000C.
6. With MDU_SIGNED_EN:
   - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM on the same operands → 0.
   - DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF.
   - MULH 0xFFFFFFFF*0xFFFFFFFF → 0x00000000.
   - Without the macro, op 5 on 0xFFFFFFF9/2 → 0x7FFFFFFC.
